// File: rtl/ks_pkg.sv
// Shared constants and helpers for the pipelined Kogge-Stone adder/subtractor.
package ks_pkg;

    localparam int KS_MIN_W = 4;
    localparam int KS_MAX_W = 64;

    // Accept-to-OUT_VALID latency: operand rank + prefix ranks + output rank.
    function automatic int ks_lat(input int width, input int reg_every);
        int levels;
        levels = $clog2(width);
        return 2 + (levels + reg_every - 1) / reg_every;
    endfunction

    function automatic bit ks_cfg_ok(input int width, input int reg_every);
        return (width >= KS_MIN_W) && (width <= KS_MAX_W) &&
               ((width & (width - 1)) == 0) &&
               (reg_every >= 1) && (reg_every <= $clog2(width));
    endfunction

endpackage

// File: rtl/black_cell.sv
// Prefix black cell: group generate and group propagate.
module black_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    input  logic p_lo,
    output logic g,
    output logic p
);
    assign g = g_hi | (p_hi & g_lo);
    assign p = p_hi & p_lo;
endmodule

// File: rtl/buffer.sv
// Prefix pass-through cell for bits that are already resolved.
module buffer (
    input  logic g_in,
    input  logic p_in,
    output logic g_out,
    output logic p_out
);
    assign g_out = g_in;
    assign p_out = p_in;
endmodule

// File: rtl/gray_cell.sv
// Prefix gray cell: group generate only.
module gray_cell (
    input  logic g_hi,
    input  logic p_hi,
    input  logic g_lo,
    output logic g
);
    assign g = g_hi | (p_hi & g_lo);
endmodule

// File: rtl/ks_prefix_level.sv
// One combinational Kogge-Stone prefix level at span DIST, with the carry-in
// absorbed into bit 0 so every group G ends up as a true carry out.
module ks_prefix_level #(
    parameter int WIDTH = 16,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] g_in,
    input  logic [WIDTH-1:0] p_in,
    input  logic             c0,
    output logic [WIDTH-1:0] g_out,
    output logic [WIDTH-1:0] p_out
);

    // Low bits as seen by this level's black cells. Bit 0 is folded with c0
    // here; from the second level on it is already resolved, so the gray cell
    // is a logical no-op but keeps c0 on every level's interface.
    logic [DIST-1:0] g_seed;

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        if (gi < DIST) begin : g_low
            if (gi == 0) begin : g_gray
                gray_cell u_gray (
                    .g_hi (g_in[0]),
                    .p_hi (p_in[0]),
                    .g_lo (c0),
                    .g    (g_seed[0])
                );
            end else begin : g_fwd
                assign g_seed[gi] = g_in[gi];
            end
            buffer u_buf (
                .g_in  (g_seed[gi]),
                .p_in  (p_in[gi]),
                .g_out (g_out[gi]),
                .p_out (p_out[gi])
            );
        end else begin : g_black
            logic g_partner;
            // Partners below DIST take the c0-folded value so bit 1 resolves at level 1.
            if (gi - DIST < DIST) begin : g_from_seed
                assign g_partner = g_seed[gi-DIST];
            end else begin : g_from_in
                assign g_partner = g_in[gi-DIST];
            end
            black_cell u_black (
                .g_hi (g_in[gi]),
                .p_hi (p_in[gi]),
                .g_lo (g_partner),
                .p_lo (p_in[gi-DIST]),
                .g    (g_out[gi]),
                .p    (p_out[gi])
            );
        end
    end

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone adder/subtractor with valid/ready handshake; the whole
// pipe advances together and stalls only on output backpressure.
module ks_adder_pipe
    import ks_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int REG_EVERY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int LOG2W = $clog2(WIDTH);

    if (!ks_cfg_ok(WIDTH, REG_EVERY)) begin : g_cfg_err
        $error("ks_adder_pipe: unsupported WIDTH/REG_EVERY combination");
    end

    // Per-level view of the pipe: index l is the value entering level l+1,
    // either straight from the previous level or from a register rank.
    logic [WIDTH-1:0] g_src  [0:LOG2W];
    logic [WIDTH-1:0] p_src  [0:LOG2W];
    logic [WIDTH-1:0] po_src [0:LOG2W];
    logic             c0_src [0:LOG2W];
    logic             vld_src[0:LOG2W];

    logic adv;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    logic [WIDTH-1:0] bx;
    logic [WIDTH-1:0] g0_reg, p0_reg;
    logic             c0_reg, vld0_reg;

    assign bx = sub ? ~b : b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g0_reg   <= '0;
            p0_reg   <= '0;
            c0_reg   <= 1'b0;
            vld0_reg <= 1'b0;
        end else if (adv) begin
            g0_reg   <= a & bx;
            p0_reg   <= a ^ bx;
            c0_reg   <= sub | cin;
            vld0_reg <= in_valid;
        end
    end

    assign g_src[0]   = g0_reg;
    assign p_src[0]   = p0_reg;
    assign po_src[0]  = p0_reg;
    assign c0_src[0]  = c0_reg;
    assign vld_src[0] = vld0_reg;

    for (genvar gi = 1; gi <= LOG2W; gi++) begin : g_level
        logic [WIDTH-1:0] g_lvl, p_lvl;

        ks_prefix_level #(
            .WIDTH (WIDTH),
            .DIST  (1 << (gi - 1))
        ) u_level (
            .g_in  (g_src[gi-1]),
            .p_in  (p_src[gi-1]),
            .c0    (c0_src[gi-1]),
            .g_out (g_lvl),
            .p_out (p_lvl)
        );

        if ((gi % REG_EVERY == 0) || (gi == LOG2W)) begin : g_rank
            logic [WIDTH-1:0] g_reg, p_reg, po_reg;
            logic             c0_reg, vld_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    g_reg   <= '0;
                    p_reg   <= '0;
                    po_reg  <= '0;
                    c0_reg  <= 1'b0;
                    vld_reg <= 1'b0;
                end else if (adv) begin
                    g_reg   <= g_lvl;
                    p_reg   <= p_lvl;
                    po_reg  <= po_src[gi-1];
                    c0_reg  <= c0_src[gi-1];
                    vld_reg <= vld_src[gi-1];
                end
            end

            assign g_src[gi]   = g_reg;
            assign p_src[gi]   = p_reg;
            assign po_src[gi]  = po_reg;
            assign c0_src[gi]  = c0_reg;
            assign vld_src[gi] = vld_reg;
        end else begin : g_comb
            assign g_src[gi]   = g_lvl;
            assign p_src[gi]   = p_lvl;
            assign po_src[gi]  = po_src[gi-1];
            assign c0_src[gi]  = c0_src[gi-1];
            assign vld_src[gi] = vld_src[gi-1];
        end
    end

    // Every G is now the carry out of its bit; shift up by one for carry-in.
    logic [WIDTH-1:0] g_fin;
    assign g_fin = g_src[LOG2W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else if (adv) begin
            out_valid <= vld_src[LOG2W];
            sum       <= po_src[LOG2W] ^ {g_fin[WIDTH-2:0], c0_src[LOG2W]};
            cout      <= g_fin[WIDTH-1];
            ovf       <= g_fin[WIDTH-2] ^ g_fin[WIDTH-1];
        end
    end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe (WIDTH=16, REG_EVERY=1): directed vectors,
// stall/backpressure, mid-flight reset and a random valid/ready sweep.
module tb_ks_adder_pipe;

    localparam int W       = 16;
    localparam int R       = 1;
    localparam int EXP_LAT = 6;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    typedef struct packed {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;

    ks_adder_pipe #(.WIDTH(W), .REG_EVERY(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic cv, input logic sv);
        logic [W-1:0] bxv;
        logic [W:0]   t;
        res_t         r;
        bxv    = sv ? ~bv : bv;
        t      = {1'b0, av} + {1'b0, bxv} + {{W{1'b0}}, (sv | cv)};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (av[W-1] == bxv[W-1]) && (t[W-1] != av[W-1]);
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Output monitor: every consumed result is popped and compared in order.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got sum=%h cout=%b ovf=%b, required no output",
                         sum, cout, ovf);
            end else begin
                res_t e;
                e = sb.pop_front();
                n_out++;
                if ({sum, cout, ovf} !== e) begin
                    errors++;
                    $display("FAIL result #%0d: got sum=%h cout=%b ovf=%b, required sum=%h cout=%b ovf=%b",
                             n_out, sum, cout, ovf, e.sum, e.cout, e.ovf);
                end else begin
                    $display("result #%0d: sum=%h cout=%b ovf=%b ok", n_out, sum, cout, ovf);
                end
            end
        end
    end

    // Holds the beat until accepted; returns at posedge+1 of the accepting edge.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv, input res_t exp);
        int guard;
        bit done;
        a = av; b = bv; cin = cv; sub = sv; in_valid = 1'b1;
        guard = 0;
        done  = 0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp);
                done = 1;
            end
            @(posedge clk); #1;
            guard++;
            if (!done && guard >= 200) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: in_ready=0 for %0d cycles, required 1", guard);
                done = 1;
            end
        end
    endtask

    task automatic drain(output int left);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        left = sb.size();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (sum !== '0) begin errors++; $display("FAIL reset_sum: got %h, required 0000", sum); end
        checks++;
        if ({cout, ovf} !== 2'b00) begin errors++; $display("FAIL reset_flags: got cout=%b ovf=%b, required 0 0", cout, ovf); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        @(posedge clk); #1;
        $display("test_reset done");
    endtask

    task automatic test_latency();
        int lat;
        int left;
        res_t e;
        e = {16'h5555, 1'b0, 1'b0};
        out_ready = 1'b1;
        send(16'h1234, 16'h4321, 1'b0, 1'b0, e);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (lat != EXP_LAT) begin errors++; $display("FAIL latency: got %0d cycles, required %0d", lat, EXP_LAT); end
        checks++;
        if (sum !== 16'h5555) begin errors++; $display("FAIL latency_sum: got %h, required 5555", sum); end
        drain(left);
        checks++;
        if (left != 0) begin errors++; $display("FAIL latency_drain: %0d outstanding, required 0", left); end
        $display("test_latency done: %0d cycles", lat);
    endtask

    task automatic test_arith();
        int   left;
        int   base;
        res_t e;
        vec_t tv [12] = '{
            {16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0},
            {16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
            {16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1},
            {16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0},
            {16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0},
            {16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0},
            {16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1},
            {16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0},
            {16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0},
            {16'hAAAA, 16'h5555, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0},
            {16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0},
            {16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1}
        };
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            e = {tv[i].sum, tv[i].cout, tv[i].ovf};
            send(tv[i].a, tv[i].b, tv[i].cin, tv[i].sub, e);
        end
        in_valid = 1'b0;
        drain(left);
        checks++;
        if (left != 0 || n_out - base != 12) begin
            errors++;
            $display("FAIL arith_count: got %0d results (%0d outstanding), required 12", n_out - base, left);
        end
        $display("test_arith done");
    endtask

    task automatic test_back_to_back();
        int           left;
        int           base;
        int           g;
        logic [W-1:0] hold_sum;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        base = n_out;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    av = W'(16'h1111 * (i + 1));
                    bv = W'(16'h0F0F + i);
                    send(av, bv, 1'b0, 1'b0, model(av, bv, 1'b0, 1'b0));
                end
                in_valid = 1'b0;
            end
            begin
                g = 0;
                while (!out_valid && g < 50) begin
                    @(posedge clk); #1;
                    g++;
                end
                repeat (2) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                @(negedge clk);
                hold_sum = sum;
                checks++;
                if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
                for (int k = 0; k < 2; k++) begin
                    @(posedge clk); @(negedge clk);
                    checks++;
                    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b, required 0", in_ready); end
                    checks++;
                    if (out_valid !== 1'b1 || sum !== hold_sum) begin
                        errors++;
                        $display("FAIL stall_hold: got valid=%b sum=%h, required valid=1 sum=%h", out_valid, sum, hold_sum);
                    end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        drain(left);
        checks++;
        if (left != 0 || n_out - base != 10) begin
            errors++;
            $display("FAIL b2b_count: got %0d results (%0d outstanding), required 10", n_out - base, left);
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_flight();
        int base;
        int g;
        out_ready = 1'b0;
        send(16'h0101, 16'h0202, 1'b0, 1'b0, model(16'h0101, 16'h0202, 1'b0, 1'b0));
        send(16'h0303, 16'h0404, 1'b1, 1'b0, model(16'h0303, 16'h0404, 1'b1, 1'b0));
        send(16'h0505, 16'h0606, 1'b0, 1'b1, model(16'h0505, 16'h0606, 1'b0, 1'b1));
        in_valid = 1'b0;
        base = n_out;
        g = 0;
        while (!out_valid && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_setup: out_valid=%b, required 1", out_valid); end
        rst = 1'b1;
        sb.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flight_reset: out_valid=%b, required 0", out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (n_out != base) begin errors++; $display("FAIL flight_discard: got %0d results, required 0", n_out - base); end
        $display("test_reset_flight done");
    endtask

    task automatic test_random(input int nbeats);
        int           left;
        int           base;
        bit           done;
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         cv;
        logic         sv;
        base = n_out;
        done = 0;
        fork
            begin
                for (int i = 0; i < nbeats; i++) begin
                    av = pick();
                    bv = pick();
                    cv = 1'($urandom_range(0, 1));
                    sv = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) begin
                        in_valid = 1'b0;
                        @(posedge clk); #1;
                    end
                    send(av, bv, cv, sv, model(av, bv, cv, sv));
                end
                in_valid = 1'b0;
                done = 1;
            end
            begin
                while (!done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain(left);
        checks++;
        if (left != 0 || n_out - base != nbeats) begin
            errors++;
            $display("FAIL random_count: got %0d results (%0d outstanding), required %0d", n_out - base, left, nbeats);
        end
        $display("test_random done");
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_back_to_back();
        test_reset_flight();
        test_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
